// File: rtl/mta_system.sv
// Inject/broadcast-eject word buffer: ReLU on inject, FIFO head broadcast to every
// eject port, popped once all ports have taken it; per-tile completion flags.
module mta_system #(
    parameter int unsigned DW    = 32,
    parameter int unsigned EPN   = 2,
    parameter int unsigned NW    = 2,
    parameter int unsigned NH    = 2,
    parameter int unsigned ITW   = 2,
    parameter int unsigned ITH   = 2,
    parameter int unsigned ITC   = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk_nw,
    input  logic          rstn_nw,
    input  logic [DW-1:0] data_i_inject,
    input  logic          valid_i_inject,
    output logic          ready_o_inject,
    output logic [DW-1:0] data_o_eject  [EPN],
    output logic          valid_o_eject [EPN],
    input  logic          ready_i_eject [EPN],
    output logic          tile_done     [NW][NH]
);

    localparam int unsigned T  = NW * NH;
    localparam int unsigned N  = ITW * ITH * ITC;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] N_C     = CW'(N);
    localparam logic [FW-1:0] DEPTH_C = FW'(DEPTH);

    logic [DW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [FW-1:0]  fcnt;
    logic [CW-1:0]  in_cnt, out_cnt, out_cnt_nxt;
    logic [EPN-1:0] taken, take;
    logic           fifo_full, fifo_empty, push, pop;
    logic [DW-1:0]  relu_word;

    // Pop count after which the last word of tile t has left the FIFO.
    function automatic logic [CW-1:0] tile_thr(input int unsigned t);
        if (t < N)
            tile_thr = CW'(t + T * ((N - 1 - t) / T) + 1);
        else
            tile_thr = N_C;
    endfunction

    always_comb begin
        fifo_full      = (fcnt == DEPTH_C);
        fifo_empty     = (fcnt == '0);
        ready_o_inject = rstn_nw & ~fifo_full & (in_cnt < N_C);
        push           = valid_i_inject & ready_o_inject;
        relu_word      = data_i_inject[DW-1] ? '0 : data_i_inject;
        take           = '0;
        for (int unsigned p = 0; p < EPN; p++) begin
            data_o_eject[p]  = mem[rd_ptr];
            valid_o_eject[p] = ~fifo_empty & ~taken[p];
            take[p]          = valid_o_eject[p] & ready_i_eject[p];
        end
        pop         = ~fifo_empty & (&(taken | take));
        out_cnt_nxt = (pop && out_cnt != N_C) ? out_cnt + 1'b1 : out_cnt;
    end

    always_ff @(posedge clk_nw or negedge rstn_nw) begin
        if (!rstn_nw) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fcnt    <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            taken   <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= relu_word;
                wr_ptr      <= wr_ptr + 1'b1;
                in_cnt      <= in_cnt + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fcnt <= fcnt + 1'b1;
            else if (pop && !push)
                fcnt <= fcnt - 1'b1;
            taken   <= pop ? '0 : (taken | take);
            out_cnt <= out_cnt_nxt;
        end
    end

    always_ff @(posedge clk_nw or negedge rstn_nw) begin
        if (!rstn_nw) begin
            for (int unsigned x = 0; x < NW; x++)
                for (int unsigned y = 0; y < NH; y++)
                    tile_done[x][y] <= 1'b0;
        end else begin
            for (int unsigned x = 0; x < NW; x++)
                for (int unsigned y = 0; y < NH; y++)
                    if (out_cnt_nxt >= tile_thr(x * NH + y)) tile_done[x][y] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mta_system.sv
// Randomized scoreboard bench for mta_system: driver queues expected ReLU words per
// port on each accepted inject; a negedge monitor checks ejects, valids, ready and tiles.
module tb_mta_system;

    localparam int DW = 32, EPN = 2, NW = 2, NH = 2, DEPTH = 4;
    localparam int N = 8, T = NW * NH;

    logic          clk_nw = 1'b0;
    logic          rstn_nw = 1'b0;
    logic [DW-1:0] data_i_inject = '0;
    logic          valid_i_inject = 1'b0;
    logic          ready_o_inject;
    logic [DW-1:0] data_o_eject  [EPN];
    logic          valid_o_eject [EPN];
    logic          ready_i_eject [EPN];
    logic          tile_done     [NW][NH];

    int checks = 0, passes = 0;
    int accepted = 0;
    int delivered [EPN];
    logic [DW-1:0] exp_q [EPN][$];
    int sink_mode = 1;  // 0 none, 1 all, 2 random, 3 port0 only
    logic [DW-1:0] frame [8];
    int inj_done = 0;
    int mn;
    logic expv;

    always #5 clk_nw = ~clk_nw;

    mta_system #(.DW(DW), .EPN(EPN), .NW(NW), .NH(NH), .ITW(2), .ITH(2), .ITC(2), .DEPTH(DEPTH)) dut (
        .clk_nw(clk_nw), .rstn_nw(rstn_nw),
        .data_i_inject(data_i_inject), .valid_i_inject(valid_i_inject), .ready_o_inject(ready_o_inject),
        .data_o_eject(data_o_eject), .valid_o_eject(valid_o_eject), .ready_i_eject(ready_i_eject),
        .tile_done(tile_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] relu(input logic [31:0] w);
        return w[31] ? 32'h0 : w;
    endfunction

    // Tile t is done once every frame index k with k mod T == t has been popped.
    function automatic logic tile_model(input int t, input int pops);
        if (t >= N) return pops == N;
        for (int k = 0; k < N; k++)
            if (k % T == t && k >= pops) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        for (int p = 0; p < EPN; p++) ready_i_eject[p] = 1'b0;
        forever begin
            @(posedge clk_nw); #1;
            for (int p = 0; p < EPN; p++)
                case (sink_mode)
                    0: ready_i_eject[p] = 1'b0;
                    1: ready_i_eject[p] = 1'b1;
                    2: ready_i_eject[p] = 1'($urandom_range(0, 1));
                    default: ready_i_eject[p] = (p == 0);
                endcase
        end
    end

    always @(negedge clk_nw) begin
        if (rstn_nw) begin
            mn = delivered[0];
            for (int p = 1; p < EPN; p++) if (delivered[p] < mn) mn = delivered[p];
            chk("ready_o_inject", 32'(ready_o_inject), 32'((accepted < N) && (accepted - mn < DEPTH)));
            for (int x = 0; x < NW; x++)
                for (int y = 0; y < NH; y++)
                    chk($sformatf("tile_done[%0d][%0d]", x, y), 32'(tile_done[x][y]), 32'(tile_model(x * NH + y, mn)));
            for (int p = 0; p < EPN; p++) begin
                expv = (delivered[p] == mn) && (mn < accepted);
                chk($sformatf("valid_o_eject[%0d]", p), 32'(valid_o_eject[p]), 32'(expv));
                if (valid_o_eject[p] && ready_i_eject[p]) begin
                    if (exp_q[p].size() == 0) chk($sformatf("eject_unexpected[%0d]", p), 32'd1, 32'd0);
                    else begin
                        chk($sformatf("data_o_eject[%0d]", p), data_o_eject[p], exp_q[p].pop_front());
                        delivered[p]++;
                    end
                end
            end
        end
    end

    task automatic clear_model();
        accepted = 0;
        for (int p = 0; p < EPN; p++) begin
            delivered[p] = 0;
            exp_q[p].delete();
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_ready"}, 32'(ready_o_inject), 32'd0);
        for (int p = 0; p < EPN; p++) begin
            chk({tag, "_valid"}, 32'(valid_o_eject[p]), 32'd0);
            chk({tag, "_data"}, data_o_eject[p], 32'd0);
        end
        for (int x = 0; x < NW; x++)
            for (int y = 0; y < NH; y++)
                chk({tag, "_tile"}, 32'(tile_done[x][y]), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk_nw); #2;
        rstn_nw = 1'b0;
        #1;
        check_cleared("rst_async");
        clear_model();
        repeat (2) @(posedge clk_nw);
        #1;
        check_cleared("rst_hold");
        #1 rstn_nw = 1'b1;
        #1 chk("ready_after_release", 32'(ready_o_inject), 32'd1);
    endtask

    task automatic inject(input logic [31:0] w);
        int n;
        logic acc;
        @(posedge clk_nw); #1;
        data_i_inject  = w;
        valid_i_inject = 1'b1;
        n = 0;
        do begin
            @(negedge clk_nw);
            acc = ready_o_inject;
            @(posedge clk_nw);
            n++;
        end while (!acc && n < 500);
        if (acc) begin
            for (int p = 0; p < EPN; p++) exp_q[p].push_back(relu(w));
            accepted++;
        end else chk("inject_timeout", 32'd0, 32'd1);
        #1 valid_i_inject = 1'b0;
    endtask

    task automatic send_frame(input int gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps != 0) repeat ($urandom_range(0, 2)) @(posedge clk_nw);
            inject(frame[i]);
        end
        inj_done = 1;
    endtask

    task automatic drain();
        int n;
        logic busy;
        n = 0;
        do begin
            @(posedge clk_nw); #1;
            busy = 1'b0;
            for (int p = 0; p < EPN; p++) if (delivered[p] != accepted) busy = 1'b1;
            n++;
        end while (busy && n < 1000);
        if (busy) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame_end(input string tag);
        @(posedge clk_nw); #1;
        chk({tag, "_ready_low"}, 32'(ready_o_inject), 32'd0);
        for (int p = 0; p < EPN; p++) chk({tag, "_count"}, 32'(delivered[p]), 32'(N));
        for (int x = 0; x < NW; x++)
            for (int y = 0; y < NH; y++)
                chk({tag, "_tile"}, 32'(tile_done[x][y]), 32'd1);
    endtask

    initial begin
        clear_model();
        rstn_nw = 1'b0;
        repeat (2) @(posedge clk_nw);
        #1 check_cleared("por");
        #1 rstn_nw = 1'b1;
        #1 chk("ready_after_por", 32'(ready_o_inject), 32'd1);

        // Streaming frame with all sinks ready, then an offer past the frame end
        sink_mode = 1;
        frame = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000,
                  32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
        send_frame(0);
        drain();
        check_frame_end("stream");
        data_i_inject  = 32'h41000000;
        valid_i_inject = 1'b1;
        repeat (4) @(posedge clk_nw);
        #1 valid_i_inject = 1'b0;
        chk("no_extra_accept", 32'(accepted), 32'(N));

        // ReLU corners plus random words, random sinks and gaps
        do_reset();
        sink_mode = 2;
        frame[0] = 32'hBF800000;
        frame[1] = 32'h80000000;
        frame[2] = 32'h7F7FFFFF;
        for (int i = 3; i < N; i++) frame[i] = $urandom;
        send_frame(1);
        drain();
        check_frame_end("relu");

        // Back-pressure: port 1 stalled while port 0 keeps accepting
        do_reset();
        sink_mode = 3;
        for (int i = 0; i < N; i++) frame[i] = $urandom & 32'h7FFFFFFF;
        inj_done = 0;
        fork
            send_frame(0);
        join_none
        repeat (50) @(posedge clk_nw);
        #1;
        chk("bp_port0_once", 32'(delivered[0]), 32'd1);
        chk("bp_port1_none", 32'(delivered[1]), 32'd0);
        chk("bp_valid0_low", 32'(valid_o_eject[0]), 32'd0);
        chk("bp_ready_low", 32'(ready_o_inject), 32'd0);
        chk("bp_fifo_words", 32'(accepted), 32'(DEPTH));
        sink_mode = 1;
        for (int n = 0; n < 1000 && inj_done == 0; n++) @(posedge clk_nw);
        chk("bp_inject_done", 32'(inj_done), 32'd1);
        drain();
        check_frame_end("bp");

        // Mid-frame reset after three accepted words, then a fresh random frame
        do_reset();
        sink_mode = 0;
        for (int i = 0; i < 3; i++) inject($urandom);
        chk("mid_accepted", 32'(accepted), 32'd3);
        do_reset();
        sink_mode = 2;
        for (int i = 0; i < N; i++) frame[i] = $urandom;
        send_frame(1);
        drain();
        check_frame_end("fresh");

        repeat (3) @(posedge clk_nw);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

endmodule
